// File: rtl/mem_port_arbiter_if.sv
// Bundle of the three memory-side handshakes around mem_port_arbiter:
//   cpu_*  : CPU requester (req held until ack, stall back to the core)
//   ldr_*  : program loader / DMA requester (same handshake, no stall)
//   mem_*  : single shared memory port (req held until single-cycle ready)
// Modports:
//   master : the arbiter's view (consumes requests, drives the memory port)
//   slave  : the environment's view (requesters plus memory model)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the core's unified memory port.
// The CPU normally wins a contested slot; the loader is forced in once the
// CPU has taken STARVE_LIM consecutive grants while the loader was waiting.
// One transaction at a time: IDLE -> *_BUSY (mem_req high until mem_ready)
// -> DONE (one-cycle ack to the owner) -> IDLE.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : master modport of mem_port_arbiter_if (cpu_*, ldr_*, mem_*)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  mem_port_arbiter_if.master  bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StCpuBusy, StLdrBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   starve_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              cpu_ack_q;
  logic              ldr_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;

  logic grant_ldr;

  // Loader wins when alone, or when it has waited out STARVE_LIM CPU grants.
  assign grant_ldr = bus.ldr_req & (~bus.cpu_req | (starve_q == StarveMax));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_ldr) begin
            state_q     <= StLdrBusy;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.ldr_we;
            mem_addr_q  <= bus.ldr_addr;
            mem_wdata_q <= bus.ldr_wdata;
            starve_q    <= '0;
          end else if (bus.cpu_req) begin
            state_q     <= StCpuBusy;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.cpu_we;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            // Count only grants the loader actually lost; saturate at the limit.
            if (!bus.ldr_req) begin
              starve_q <= '0;
            end else if (starve_q != StarveMax) begin
              starve_q <= starve_q + CntW'(1);
            end
          end
        end
        StCpuBusy, StLdrBusy: begin
          if (bus.mem_ready) begin
            state_q   <= StDone;
            mem_req_q <= 1'b0;
            if (state_q == StCpuBusy) begin
              cpu_ack_q <= 1'b1;
              if (!mem_we_q) cpu_rdata_q <= bus.mem_rdata;
            end else begin
              ldr_ack_q <= 1'b1;
              if (!mem_we_q) ldr_rdata_q <= bus.mem_rdata;
            end
          end
        end
        StDone: begin
          // Requests are ignored here so the owner can drop/renew req safely.
          state_q   <= StIdle;
          cpu_ack_q <= 1'b0;
          ldr_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          cpu_ack_q <= 1'b0;
          ldr_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  // Core freezes while its request is outstanding; releases in the ack cycle.
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          LIM  = 4;
  localparam int          NCyc = 1000;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        pend;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Memory contents seen by the reference model; unwritten words read a pattern.
  logic [31:0] mem_m [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  req_t creq, lreq;

  // Transaction-level reference: one transaction occupies the port from the
  // cycle after its grant until ready, ack follows, next grant two cycles later.
  bit          busy;
  bit          own_ldr;
  req_t        txn;
  int          free_at;
  int          starve;
  bit          e_req, e_cack, e_lack;
  logic [31:0] e_crd, e_lrd;
  bit          glog[$];

  task automatic drive();
    bus.cpu_req   = creq.pend;
    bus.cpu_we    = creq.we;
    bus.cpu_addr  = creq.addr;
    bus.cpu_wdata = creq.wdata;
    bus.ldr_req   = lreq.pend;
    bus.ldr_we    = lreq.we;
    bus.ldr_addr  = lreq.addr;
    bus.ldr_wdata = lreq.wdata;
  endtask

  task automatic new_req(inout req_t r);
    r.pend  = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 32'($urandom_range(0, 31)) << 2;
    r.wdata = $urandom;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "mem_req"},   bus.mem_req,   0);
    check({pfx, "mem_we"},    bus.mem_we,    0);
    check({pfx, "mem_addr"},  bus.mem_addr,  0);
    check({pfx, "mem_wdata"}, bus.mem_wdata, 0);
    check({pfx, "cpu_ack"},   bus.cpu_ack,   0);
    check({pfx, "ldr_ack"},   bus.ldr_ack,   0);
    check({pfx, "cpu_rdata"}, bus.cpu_rdata, 0);
    check({pfx, "ldr_rdata"}, bus.ldr_rdata, 0);
  endtask

  task automatic model_reset();
    busy    = 1'b0;
    own_ldr = 1'b0;
    txn     = '0;
    free_at = 0;
    starve  = 0;
    e_req   = 1'b0;
    e_cack  = 1'b0;
    e_lack  = 1'b0;
    e_crd   = '0;
    e_lrd   = '0;
  endtask

  initial begin
    int  pc, pl, pr, cpu_quiet;
    bit  rst_done, rst_evt, n_req, n_c, n_l;

    creq = '0;
    lreq = '0;
    rst_n = 1'b0;
    drive();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    mem_m[32'h40] = 32'hDEAD_BEEF;
    model_reset();
    rst_done  = 1'b0;
    cpu_quiet = -1;

    #1;
    check_zero("rst_");

    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;

      // Outputs of this cycle against the model.
      check("mem_req",   bus.mem_req,   e_req);
      check("cpu_ack",   bus.cpu_ack,   e_cack);
      check("ldr_ack",   bus.ldr_ack,   e_lack);
      check("cpu_stall", bus.cpu_stall, creq.pend & ~e_cack);
      check("cpu_rdata", bus.cpu_rdata, e_crd);
      check("ldr_rdata", bus.ldr_rdata, e_lrd);
      if (e_req) begin
        check("mem_we",    bus.mem_we,    txn.we);
        check("mem_addr",  bus.mem_addr,  txn.addr);
        check("mem_wdata", bus.mem_wdata, txn.wdata);
      end
      if (cyc < 120) begin
        if (bus.cpu_ack) glog.push_back(1'b0);
        if (bus.ldr_ack) glog.push_back(1'b1);
      end
      if (cyc == 120) begin
        // Both held continuously from reset: C,C,C,C,L repeating.
        check("grant_count", glog.size() >= 10, 1);
        for (int i = 0; i < 10; i++) check($sformatf("grant_order%0d", i), glog[i], (i % 5) == 4);
      end

      // Requesters drop or renew on the edge that ends the ack cycle.
      if (e_cack) creq.pend = 1'b0;
      if (e_lack) lreq.pend = 1'b0;

      if (cyc < 120) begin
        pc = 100; pl = 100; pr = 50;
      end else if (cyc < 600) begin
        pc = 40;  pl = 40;  pr = 50;
      end else if (cyc < 660) begin
        pc = 100; pl = 0;   pr = 100;
      end else begin
        pc = 30;  pl = 30;  pr = 40;
      end
      if (cyc < cpu_quiet) pc = 0;
      if (!creq.pend && $urandom_range(0, 99) < pc) new_req(creq);
      if (!lreq.pend && $urandom_range(0, 99) < pl) new_req(lreq);
      drive();

      rst_evt = (cyc >= 700) && !rst_done && busy;
      bus.mem_ready = rst_evt ? 1'b0 : ($urandom_range(0, 99) < pr);
      bus.mem_rdata = busy ? mem_rd(txn.addr) : $urandom;

      n_req = 1'b0; n_c = 1'b0; n_l = 1'b0;
      if (busy) begin
        if (bus.mem_ready) begin
          if (txn.we) mem_m[txn.addr] = txn.wdata;
          else if (own_ldr) e_lrd = mem_rd(txn.addr);
          else e_crd = mem_rd(txn.addr);
          if (own_ldr) n_l = 1'b1; else n_c = 1'b1;
          busy    = 1'b0;
          free_at = cyc + 2;
        end else begin
          n_req = 1'b1;
        end
      end else if (cyc >= free_at && (creq.pend || lreq.pend)) begin
        own_ldr = lreq.pend && (!creq.pend || starve == LIM);
        if (own_ldr) begin
          txn    = lreq;
          starve = 0;
        end else begin
          txn    = creq;
          starve = lreq.pend ? ((starve < LIM) ? starve + 1 : LIM) : 0;
        end
        busy  = 1'b1;
        n_req = 1'b1;
      end
      e_req  = n_req;
      e_cack = n_c;
      e_lack = n_l;

      if (rst_evt) begin
        // Abandon the in-flight transaction; outputs must clear without an edge.
        #2 rst_n = 1'b0;
        #1 check_zero("midrst_");
        rst_done = 1'b1;
        model_reset();
        creq      = '0;
        lreq      = '0;
        lreq.pend = 1'b1;
        lreq.addr = 32'h40;
        cpu_quiet = cyc + 12;
        drive();
      end
    end

    check("reset_event_hit", rst_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
